// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
// Operation encoding follows the RV64M funct3 field.
package mdu_pkg;

  localparam int MDU_XLEN = 64;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic [63:0] abs64(
    input logic [63:0] x,
    input logic        is_signed
  );
    return (is_signed && x[63]) ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit, one radix-2 step per cycle.
// Multiply and divide share one 128-bit shift register (hi = product-high / remainder).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int STEPS = MDU_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(STEPS);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t state_q;
  mdu_state_t state_d;

  mdu_op_t           op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;

  logic            sgn1;
  logic            sgn2;
  logic            s1;
  logic            s2;
  logic            is_div;
  logic            is_rem;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;
  logic            last;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] step_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_res;

  // Request decode
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (op)
      MULH:    begin sgn1 = 1'b1; sgn2 = 1'b1; end
      MULHSU:  sgn1 = 1'b1;
      DIV:     begin sgn1 = 1'b1; sgn2 = 1'b1; end
      REM:     begin sgn1 = 1'b1; sgn2 = 1'b1; end
      default: ;
    endcase
  end

  assign s1 = sgn1 & rs1[XLEN-1];
  assign s2 = sgn2 & rs2[XLEN-1];

  assign is_div = op inside {DIV, DIVU, REM, REMU};
  assign is_rem = op inside {REM, REMU};

  assign div_zero = is_div && (rs2 == '0);
  assign ovf = (op == DIV || op == REM)
            && (rs1 == MIN_NEG)
            && (rs2 == '1);
  assign special = div_zero || ovf;

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div_zero && is_rem:  spec_res = rs1;
      div_zero && !is_rem: spec_res = '1;
      ovf && !is_rem:      spec_res = MIN_NEG;
      default:             spec_res = '0;
    endcase
  end

  // One iteration of either algorithm
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q}
                             : {(XLEN+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  // Partial remainder can reach 2*divisor-1, so trial needs 65 bits
  assign trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};

  always_comb begin
    if (!trial[XLEN])
      div_nxt = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      div_nxt = {acc_q[2*XLEN-2:0], 1'b0};
  end

  assign step_nxt = (op_q inside {DIV, DIVU, REM, REMU})
                  ? div_nxt : mul_nxt;

  // Sign correction applied to the final iteration's output
  assign prod = neg_q ? -step_nxt : step_nxt;
  assign quo  = neg_q ? -step_nxt[XLEN-1:0]
                      : step_nxt[XLEN-1:0];
  assign rem  = neg_q ? -step_nxt[2*XLEN-1:XLEN]
                      : step_nxt[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = '0;
    unique case (op_q)
      MUL:                 fin_res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: fin_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           fin_res = quo;
      REM, REMU:           fin_res = rem;
      default:             fin_res = '0;
    endcase
  end

  assign last = (cnt_q == CW'(STEPS-1));

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) state_d = special ? DONE : BUSY;
        BUSY: if (last)     state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= MUL;
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      result <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            cnt_q  <= '0;
            opnd_q <= abs64(rs2, sgn2);
            acc_q  <= {{XLEN{1'b0}}, abs64(rs1, sgn1)};
            // Remainder takes the dividend's sign only
            neg_q  <= is_rem ? s1 : (s1 ^ s2);
            if (special) result <= spec_res;
          end
        end
        BUSY: begin
          acc_q <= step_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last) result <= fin_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table plus handshake corner cases.
// Expected results flow through a scoreboard queue.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  mdu_op_t     op = MUL;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] sb[$];

  typedef struct {
    mdu_op_t     o;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(mdu_op_t o, logic [63:0] a,
                       logic [63:0] b, logic [63:0] exp);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    sb.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(string nm, int lat);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 200);
    chk({nm, "_latency"}, 64'(k), 64'(lat));
  endtask

  task automatic consume(string nm);
    logic [63:0] e;
    out_ready = 1'b1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(nm, result, e);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_back_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run(string nm, mdu_op_t o, logic [63:0] a,
                     logic [63:0] b, logic [63:0] exp, int lat);
    issue(o, a, b, exp);
    wait_done(nm, lat);
    consume(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] p;

    vecs.push_back('{MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                     64'hFFFF_FFFF_FFFF_FFEB, 65});
    vecs.push_back('{MULHU,  M1, M1, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{MULH,   M1, M1, 64'd0, 65});
    vecs.push_back('{MULHSU, M1, 64'd2, M1, 65});
    vecs.push_back('{MUL,    64'h1234_5678_9ABC_DEF0, 64'h10,
                     64'h2345_6789_ABCD_EF00, 65});
    vecs.push_back('{MULHU,  64'h1234_5678_9ABC_DEF0, 64'h10,
                     64'd1, 65});
    vecs.push_back('{DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 65});
    vecs.push_back('{REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, M1, 65});
    vecs.push_back('{DIVU, 64'd100, 64'd7, 64'd14, 65});
    vecs.push_back('{REMU, 64'd100, 64'd7, 64'd2, 65});
    vecs.push_back('{DIV,  64'hFFFF_FFFF_FFFF_FFF9,
                     64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 65});
    vecs.push_back('{REM,  64'hFFFF_FFFF_FFFF_FFF9,
                     64'hFFFF_FFFF_FFFF_FFFE, M1, 65});
    vecs.push_back('{DIV,  MIN, 64'd2, 64'hC000_0000_0000_0000, 65});
    vecs.push_back('{DIVU, MIN, M1, 64'd0, 65});
    vecs.push_back('{DIV,  64'd5, 64'd0, M1, 1});
    vecs.push_back('{REM,  64'd5, 64'd0, 64'd5, 1});
    vecs.push_back('{DIVU, 64'd123, 64'd0, M1, 1});
    vecs.push_back('{REMU, 64'hDEAD, 64'd0, 64'hDEAD, 1});
    vecs.push_back('{DIV,  MIN, M1, MIN, 1});
    vecs.push_back('{REM,  MIN, M1, 64'd0, 1});

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result",    result, 64'd0);
    reset = 1'b0;

    foreach (vecs[i])
      run($sformatf("vec%0d_%s", i, vecs[i].o.name()),
          vecs[i].o, vecs[i].a, vecs[i].b,
          vecs[i].exp, vecs[i].lat);

    // random unsigned ops against 128-bit reference arithmetic
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 40);
      if (b == 0) b = 64'd3;
      p = {64'd0, a} * {64'd0, b};
      case (i % 4)
        0: run("rnd_mul",   MUL,   a, b, p[63:0], 65);
        1: run("rnd_mulhu", MULHU, a, b, p[127:64], 65);
        2: run("rnd_divu",  DIVU,  a, b, a / b, 65);
        default: run("rnd_remu", REMU, a, b, a % b, 65);
      endcase
    end

    // back-pressure in DONE, stray request ignored
    issue(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("bp", 65);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op = DIV; rs1 = 64'd9; rs2 = 64'd0; in_valid = 1'b1;
      chk("bp_hold_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("bp_release");
    run("bp_next", DIVU, 64'd100, 64'd7, 64'd14, 65);

    // flush in cycle 30 of BUSY
    issue(MUL, 64'd3, 64'd5, 64'd15);
    repeat (30) @(negedge clk);
    chk("fl_busy_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(sb.pop_back());
    chk("fl_idle", {63'd0, in_ready}, 64'd1);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("fl_no_out_valid", 64'(cnt), 64'd0);

    // flush beats in_valid in IDLE
    @(negedge clk);
    op = DIV; rs1 = 64'd1; rs2 = 64'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("fl_vs_req_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    chk("fl_vs_req_out_valid", {63'd0, out_valid}, 64'd0);

    // flush beats out_ready in DONE
    issue(DIV, 64'd5, 64'd0, M1);
    wait_done("fl_done", 1);
    flush = 1'b1; out_ready = 1'b1;
    void'(sb.pop_front());
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    chk("fl_done_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_done_in_ready",  {63'd0, in_ready},  64'd1);

    // async reset mid-BUSY after a nonzero result is held
    run("pre_rst", DIVU, 64'd100, 64'd7, 64'd14, 65);
    issue(MUL, 64'd7, 64'd9, 64'd63);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_result",    result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run("post_rst", MULHU, M1, M1, 64'hFFFF_FFFF_FFFF_FFFE, 65);

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
